// File: rtl/dmem_bank_sync_if.sv
// Request/response bus for the MEM-stage data bank: valid/ready request channel
// plus a single-cycle response pulse.
interface dmem_bank_sync_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, busy
  );
endinterface

// File: rtl/dmem_bank_sync.sv
// Byte-addressed little-endian data bank with sized/extended loads, byte-lane
// stores, optional wait states and fault reporting for bad accesses.
module dmem_bank_sync #(
  parameter int DEPTH_LOG2  = 7,
  parameter int WAIT_CYCLES = 0,
  parameter int INIT_STRIDE = 10
) (
  input  logic             clk,
  input  logic             rst,
  dmem_bank_sync_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef logic [DEPTH-1:0][31:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = 32'(i * INIT_STRIDE);
    return m;
  endfunction

  // Power-up contents only; reset deliberately leaves the array alone.
  mem_t mem_reg = init_mem();

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_fault_reg;

  logic                  accept;
  logic                  commit;
  logic                  fault;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           rd_word;
  logic [31:0]           byte_sh;
  logic [31:0]           half_sh;
  logic [31:0]           load_data;
  logic [31:0]           lane_data;
  logic [31:0]           merged;
  logic [3:0]            be;

  assign bus.req_ready  = !rst && (state_reg == IDLE || state_reg == RESP);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_fault = resp_fault_reg;

  assign accept   = bus.req_valid && bus.req_ready;
  assign commit   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign word_idx = addr_reg[DEPTH_LOG2+1:2];
  assign rd_word  = mem_reg[word_idx];

  assign fault = (size_reg == 2'b11)
              || (size_reg == 2'b01 && addr_reg[0])
              || (size_reg == 2'b10 && addr_reg[1:0] != 2'b00)
              || (|addr_reg[31:DEPTH_LOG2+2]);

  // The async reset clears state_reg only after the edge, so gate the write on rst too.
  assign mem_we = commit && wr_reg && !fault && !rst;

  always_comb begin
    byte_sh   = rd_word >> {addr_reg[1:0], 3'b000};
    half_sh   = rd_word >> {addr_reg[1], 4'b0000};
    load_data = rd_word;
    case (size_reg)
      2'b00:   load_data = uns_reg ? {24'd0, byte_sh[7:0]}  : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   load_data = uns_reg ? {16'd0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    be        = 4'b1111;
    lane_data = wdata_reg;
    case (size_reg)
      2'b00: begin
        be        = 4'b0001 << addr_reg[1:0];
        lane_data = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_reg[1], 1'b0};
        lane_data = {2{wdata_reg[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = wdata_reg;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = be[gi] ? lane_data[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (mem_we) mem_reg[word_idx] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      wr_reg         <= 1'b0;
      size_reg       <= 2'b00;
      uns_reg        <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        BUSY: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_fault_reg <= fault;
            resp_rdata_reg <= (wr_reg || fault) ? 32'd0 : load_data;
          end
        end
        RESP: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
          resp_rdata_reg <= 32'd0;
          resp_fault_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
      // Accept is only possible in IDLE or RESP and overrides the exit to IDLE.
      if (accept) begin
        state_reg <= BUSY;
        cnt_reg   <= 4'(WAIT_CYCLES);
        wr_reg    <= bus.req_write;
        size_reg  <= bus.req_size;
        uns_reg   <= bus.req_unsigned;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_bank_sync.sv
// Self-checking bench: three banks (0, 2 and 3 wait states) driven from one
// directed + random sequence, checked against a byte-array reference model.
module tb_dmem_bank_sync;
  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        ready_v   [3];
  logic        rvalid_v  [3];
  logic        fault_v   [3];
  logic        busy_v    [3];
  logic [31:0] rdata_v   [3];

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_b [3][512];

  always #5 clk = ~clk;

  function automatic int wait_of(int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  dmem_bank_sync_if bus_if [3] ();

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      assign bus_if[gi].req_valid    = req_valid && (sel == gi);
      assign bus_if[gi].req_write    = req_write;
      assign bus_if[gi].req_size     = req_size;
      assign bus_if[gi].req_unsigned = req_unsigned;
      assign bus_if[gi].req_addr     = req_addr;
      assign bus_if[gi].req_wdata    = req_wdata;
      assign ready_v[gi]  = bus_if[gi].req_ready;
      assign rvalid_v[gi] = bus_if[gi].resp_valid;
      assign fault_v[gi]  = bus_if[gi].resp_fault;
      assign busy_v[gi]   = bus_if[gi].busy;
      assign rdata_v[gi]  = bus_if[gi].resp_rdata;

      dmem_bank_sync #(
        .DEPTH_LOG2  (7),
        .WAIT_CYCLES ((gi == 0) ? 0 : (gi == 1) ? 2 : 3),
        .INIT_STRIDE (10)
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Returns {fault, rdata}; stores update the byte array.
  function automatic logic [32:0] model(int d, bit wr, logic [1:0] sz, bit un,
                                        logic [31:0] a, logic [31:0] wd);
    int n;
    int ai;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || (a % 32'(n)) != 0 || a >= 32'd512) return {1'b1, 32'd0};
    ai = int'(a);
    if (wr) begin
      for (int k = 0; k < n; k++) mem_b[d][ai+k] = wd[8*k +: 8];
      return 33'd0;
    end
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mem_b[d][ai+k]) << (8*k));
    if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return {1'b0, v};
  endfunction

  // Called at a negedge; returns at a negedge one cycle after the response.
  task automatic do_req(input int d, input bit wr, input logic [1:0] sz, input bit un,
                        input logic [31:0] a, input logic [31:0] wd, input string tag,
                        output logic [31:0] rd, output logic flt);
    logic [32:0] exp;
    int waitc;
    int lat;
    int bad;
    sel = d; req_write = wr; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    #1;
    waitc = 0;
    while (ready_v[d] !== 1'b1 && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    check({tag, "_ready"}, 32'(ready_v[d]), 32'd1);
    @(posedge clk);
    exp = model(d, wr, sz, un, a, wd);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    bad = 0;
    while (rvalid_v[d] !== 1'b1 && lat < 40) begin
      if (ready_v[d] !== 1'b0 || busy_v[d] !== 1'b1) bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(wait_of(d) + 1));
    check({tag, "_busywin"}, 32'(bad), 32'd0);
    check({tag, "_fault"}, 32'(fault_v[d]), 32'(exp[32]));
    check({tag, "_rdata"}, rdata_v[d], exp[31:0]);
    rd  = rdata_v[d];
    flt = fault_v[d];
    @(negedge clk);
    check({tag, "_pulse"}, {rvalid_v[d], rdata_v[d][30:0]}, 32'd0);
    $display("txn %-10s dut=%0d wr=%0d sz=%0d un=%0d addr=0x%08h wd=0x%08h -> rdata=0x%08h fault=%0d",
             tag, d, wr, sz, un, a, wd, rd, flt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic        f;
    logic [32:0] e;
    int          hits;

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 128; i++)
        for (int k = 0; k < 4; k++) mem_b[d][4*i+k] = 8'((i * 10) >> (8*k));

    rst = 1'b1; sel = 0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready_v[0]), 32'd0);
    check("rst_outs", {busy_v[0], fault_v[0], rvalid_v[0]}, 32'd0);
    check("rst_rdata", rdata_v[0], 32'd0);
    rst = 1'b0;

    // Power-up contents and sized loads after a byte store.
    do_req(0, 0, 2'd2, 0, 32'h0C, 32'd0, "lw0C", r, f);          check("lw0C_c", r, 32'h1E);
    do_req(0, 1, 2'd0, 0, 32'h0D, 32'hFF, "sb0D", r, f);
    do_req(0, 0, 2'd2, 0, 32'h0C, 32'd0, "lw0C_b", r, f);        check("lw0C_b_c", r, 32'h0000FF1E);
    do_req(0, 0, 2'd0, 0, 32'h0D, 32'd0, "lb0D", r, f);          check("lb0D_c", r, 32'hFFFFFFFF);
    do_req(0, 0, 2'd0, 1, 32'h0D, 32'd0, "lbu0D", r, f);         check("lbu0D_c", r, 32'h000000FF);
    do_req(0, 0, 2'd1, 0, 32'h0C, 32'd0, "lh0C", r, f);          check("lh0C_c", r, 32'hFFFFFF1E);
    do_req(0, 0, 2'd1, 1, 32'h0C, 32'd0, "lhu0C", r, f);         check("lhu0C_c", r, 32'h0000FF1E);

    // Faulting accesses.
    do_req(0, 1, 2'd2, 0, 32'h0E, 32'h12345678, "sw0E", r, f);   check("sw0E_f", 32'(f), 32'd1);
    do_req(0, 1, 2'd1, 0, 32'h0D, 32'h0000ABCD, "sh0D", r, f);   check("sh0D_f", 32'(f), 32'd1);
    do_req(0, 0, 2'd3, 0, 32'h0C, 32'd0, "sz11", r, f);          check("sz11_f", 32'(f), 32'd1);
    do_req(0, 0, 2'd2, 0, 32'h200, 32'd0, "lw200", r, f);        check("lw200_f", 32'(f), 32'd1);
    do_req(0, 0, 2'd2, 0, 32'h0C, 32'd0, "lw0C_c2", r, f);       check("lw0C_c2_c", r, 32'h0000FF1E);

    // Two wait states.
    do_req(1, 0, 2'd2, 0, 32'h08, 32'd0, "w2_lw08", r, f);       check("w2_lw08_c", r, 32'h14);

    // Back-to-back: second request accepted in the first one's RESP cycle.
    sel = 1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    #1;
    check("b2b_ready", 32'(ready_v[1]), 32'd1);
    @(posedge clk);
    e = model(1, 1, 2'd2, 0, 32'h10, 32'hCAFEF00D);
    @(negedge clk);
    req_write = 1'b0;
    repeat (wait_of(1) + 1) @(negedge clk);
    check("b2b_sw_resp", {rvalid_v[1], ready_v[1], fault_v[1]}, 32'b110);
    @(posedge clk);
    e = model(1, 0, 2'd2, 0, 32'h10, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_lw_busy", {rvalid_v[1], busy_v[1]}, 32'b01);
    repeat (wait_of(1) + 1) @(negedge clk);
    check("b2b_lw_valid", 32'(rvalid_v[1]), 32'd1);
    check("b2b_lw_rdata", rdata_v[1], e[31:0]);
    check("b2b_lw_c", rdata_v[1], 32'hCAFEF00D);
    $display("txn b2b        dut=1 sw/lw 0x10 -> rdata=0x%08h", rdata_v[1]);
    @(negedge clk);

    // Reset while a store sits in BUSY: it must never commit.
    sel = 2; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h04; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    #1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outs", {ready_v[2], busy_v[2], fault_v[2], rvalid_v[2]}, 32'd0);
    check("mid_rst_rdata", rdata_v[2], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid_v[2] === 1'b1) hits++;
    end
    check("mid_rst_noresp", 32'(hits), 32'd0);
    do_req(2, 0, 2'd2, 0, 32'h04, 32'd0, "rst_lw04", r, f);      check("rst_lw04_c", r, 32'h0A);

    // Randomized traffic across all three banks.
    for (int t = 0; t < 60; t++) begin
      int          d;
      logic [31:0] a;
      d = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(9, 31));
      do_req(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, "rand", r, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_bank_sync.md
Name: dmem_bank_sync

Overview:
- Clocked, parametrised data-memory bank for the pipelined MIPS MEM stage.
- Byte-addressed, little-endian, word-organised storage.
- Supports byte, half and word loads (signed or unsigned) and byte, half and word stores.
- Uses a valid/ready request channel and a one-cycle response pulse, with optional wait states to model slow memory.
- Flags misaligned, out-of-range and illegal-size accesses instead of silently aliasing them.

Parameters:
- DEPTH_LOG2, 7: log2 of word count (default 128 words = 512 bytes).
- WAIT_CYCLES, 0: extra cycles between request accept and the access commit (0..15).
- INIT_STRIDE, 10: power-up contents; word i = i*INIT_STRIDE (all words 0..2^DEPTH_LOG2-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bank can accept a request this cycle.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result (0 for stores and faults).
- resp_fault  out  1  access rejected; qualified by resp_valid.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_fault=0, busy=0.
  - req_ready=0 while rst is high.
  - The array is not cleared; power-up contents come from INIT_STRIDE only.
- States:
  - IDLE: req_ready=1.
  - BUSY: req_ready=0, busy=1.
  - RESP: req_ready=1, resp_valid=1, busy=1.
- Accept: at an edge where req_valid && req_ready.
  - All req_* fields are captured into internal registers.
  - State goes to BUSY with the countdown set to WAIT_CYCLES.
- BUSY, countdown != 0: decrement the countdown and stay in BUSY.
- BUSY, countdown == 0: at that edge:
  - Stores: the byte-lane write commits.
  - Loads: the extended read data registers into resp_rdata.
  - resp_fault registers, and state goes to RESP.
- Latency: request accepted at edge N gives the commit and resp_valid=1 from edge N+1+WAIT_CYCLES for exactly one cycle.
- RESP exit:
  - A request accepted in RESP goes straight to BUSY, giving a throughput of one access per WAIT_CYCLES+2 cycles.
  - Otherwise state goes to IDLE, and resp_valid, resp_rdata and resp_fault return to 0.
- Indexing: word index = addr[DEPTH_LOG2+1:2]; byte lane = addr[1:0].
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: bytes addr[1]*2 and addr[1]*2+1.
  - Word: all four bytes.
  - Extension to 32 bits follows req_unsigned (ignored for word).
- Store merge: only the addressed byte(s) change; all other bytes of the word keep their previous value.
- Faults (resp_fault=1, no write, resp_rdata=0):
  - req_size==11.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Any bit of addr[31:DEPTH_LOG2+2] set.
- Faults still take the full latency; no early response.
- Requests presented while req_ready=0 are ignored; the requester holds req_valid and its fields stable until accepted.
- Reset mid-operation (BUSY): the captured request is dropped and an uncommitted store never writes.
- Reset asserted in the same cycle as an accept: reset wins and nothing is captured.

Test Plan:
- Power-up, WAIT_CYCLES=0: lw 0x0C accepted at edge N -> resp_valid high after edge N+1 only, resp_rdata=0x0000001E, resp_fault=0.
- sb wdata=0x000000FF at 0x0D, then:
  - lw 0x0C -> 0x0000FF1E.
  - lb 0x0D -> 0xFFFFFFFF.
  - lbu 0x0D -> 0x000000FF.
  - lh 0x0C -> 0xFFFFFF1E.
  - lhu 0x0C -> 0x0000FF1E.
- sw 0x0E (misaligned), sh 0x0D, req_size=11, and lw 0x200 (DEPTH_LOG2=7) -> each gives resp_fault=1 and resp_rdata=0; a follow-up lw 0x0C is unchanged.
- WAIT_CYCLES=2: lw 0x08 accepted at edge N -> req_ready=0 during edges N+1..N+2, resp_valid exactly at edge N+3, data=0x00000014.
- Back-to-back: req_valid held high for a sw then a lw to 0x10 -> the second request is accepted in the RESP cycle of the first and returns the stored value.
- Reset pulsed while a sw to 0x04 is in BUSY (WAIT_CYCLES=3) -> outputs return to 0 immediately, no resp_valid, and a later lw 0x04 returns 0x0000000A.
